// File: rtl/panda_mem_arbiter.sv
// ---------------------------------------------------------------------------
// panda_mem_arbiter
//
// Shares one OBI-style memory port between the Panda core's instruction
// fetch port and its load-store port. Arbitration is round-robin; once a
// requester has been presented to memory without being accepted, that
// decision is held until memory grants it. A small in-order ownership FIFO
// remembers who issued each accepted transaction, so every response is
// steered back to the port that asked for it.
//
// Parameters:
//   MaxOutstanding  maximum accepted-but-unanswered transactions (>= 1)
//
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   instr_req_i / instr_addr_i    fetch request and address
//   instr_gnt_o                   fetch request accepted this cycle
//   instr_rvalid_o/instr_rdata_o  fetch response
//   data_req_i / data_addr_i      LSU request and address
//   data_we_i/data_be_i/data_wdata_i  LSU store attributes
//   data_gnt_o                    LSU request accepted this cycle
//   data_rvalid_o/data_rdata_o    LSU response (loads and stores)
//   mem_req_o .. mem_wdata_o      shared memory request channel
//   mem_gnt_i                     memory accepted the request
//   mem_rvalid_i / mem_rdata_i    in-order memory response
// ---------------------------------------------------------------------------
module panda_mem_arbiter #(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,

    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,

    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    owner_e                    last_q;
    owner_e                    lock_owner_q;
    owner_e                    owner;
    logic                      lock_q;
    logic                      owner_req;
    logic [MaxOutstanding-1:0] fifo_q;
    logic [PtrW-1:0]           rd_ptr_q;
    logic [PtrW-1:0]           wr_ptr_q;
    logic [CntW-1:0]           count_q;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      grant;
    logic                      pop;
    logic                      head_is_data;

    // Pointers wrap at MaxOutstanding, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    // Owner selection: a held (locked) decision wins outright; otherwise a
    // lone requester wins, and a tie goes to whoever was not granted last.
    always_comb begin
        owner = OWNER_INSTR;
        if (lock_q) begin
            owner = lock_owner_q;
        end else if (instr_req_i && data_req_i) begin
            owner = (last_q == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
        end else if (data_req_i) begin
            owner = OWNER_DATA;
        end
    end

    assign owner_req  = (owner == OWNER_DATA) ? data_req_i : instr_req_i;
    assign fifo_full  = (count_q == CntW'(MaxOutstanding));
    assign fifo_empty = (count_q == '0);

    // The full check uses the registered count only, so a pop in the same
    // cycle never frees a slot early; the waiting request goes next cycle.
    assign mem_req_o   = (instr_req_i | data_req_i) & ~fifo_full & rst_ni;
    assign grant       = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = grant & (owner == OWNER_INSTR);
    assign data_gnt_o  = grant & (owner == OWNER_DATA);

    // Responses with nothing outstanding are dropped rather than routed.
    assign pop            = mem_rvalid_i & ~fifo_empty & rst_ni;
    assign head_is_data   = fifo_q[rd_ptr_q];
    assign instr_rvalid_o = pop & ~head_is_data;
    assign data_rvalid_o  = pop & head_is_data;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    // Request channel mux. Fetches are always full-word reads, so their
    // write attributes are forced to a benign read.
    always_comb begin
        mem_addr_o  = instr_addr_i;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'hF;
        mem_wdata_o = '0;
        if (owner == OWNER_DATA) begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
        end
    end

    // Arbitration state and ownership FIFO. A grant records the winner for
    // fairness and queues it for response routing; an unaccepted request
    // locks the decision so the memory sees a stable request. If the locked
    // requester withdraws, the lock is released instead of re-armed.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q       <= OWNER_DATA;
            lock_q       <= 1'b0;
            lock_owner_q <= OWNER_INSTR;
            fifo_q       <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            if (grant) begin
                lock_q           <= 1'b0;
                last_q           <= owner;
                fifo_q[wr_ptr_q] <= (owner == OWNER_DATA);
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end else if (lock_q && !owner_req) begin
                lock_q <= 1'b0;
            end else if (mem_req_o) begin
                lock_q       <= 1'b1;
                lock_owner_q <= owner;
            end

            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end

            if (grant && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !grant) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    // Protocol checks on the surrounding blocks; reported as warnings since
    // the arbiter itself recovers from both cases.
    rvalid_without_outstanding: assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(mem_rvalid_i && fifo_empty))
        else $warning("panda_mem_arbiter: mem_rvalid_i with no outstanding transaction");

    locked_request_dropped: assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(lock_q && !owner_req))
        else $warning("panda_mem_arbiter: locked requester dropped its request");
`endif

endmodule

// File: tb/tb_panda_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_panda_mem_arbiter
//
// Self-checking bench for panda_mem_arbiter (MaxOutstanding = 2): a vector
// table walking through fetch, store, lock and full behaviour, hand-written
// sequences for contention, full stall and reset mid-flight, and a random
// phase compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_panda_mem_arbiter;

    localparam int MaxOut = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int pass_count  = 0;
    int check_count = 0;

    panda_mem_arbiter #(.MaxOutstanding(MaxOut)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .instr_req_i   (instr_req_i),
        .instr_addr_i  (instr_addr_i),
        .instr_gnt_o   (instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o (instr_rdata_o),
        .data_req_i    (data_req_i),
        .data_addr_i   (data_addr_i),
        .data_we_i     (data_we_i),
        .data_be_i     (data_be_i),
        .data_wdata_i  (data_wdata_i),
        .data_gnt_o    (data_gnt_o),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_we_o      (mem_we_o),
        .mem_be_o      (mem_be_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic [31:0] daddr;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] dwdata;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_igt;
        logic        e_dgt;
        logic        e_irv;
        logic        e_drv;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idleInputs();
        instr_req_i  = 1'b0;
        instr_addr_i = '0;
        data_req_i   = 1'b0;
        data_addr_i  = '0;
        data_we_i    = 1'b0;
        data_be_i    = '0;
        data_wdata_i = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    task automatic doReset();
        idleInputs();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        instr_req_i  = v.ireq;
        instr_addr_i = v.iaddr;
        data_req_i   = v.dreq;
        data_addr_i  = v.daddr;
        data_we_i    = v.dwe;
        data_be_i    = v.dbe;
        data_wdata_i = v.dwdata;
        mem_gnt_i    = v.gnt;
        mem_rvalid_i = v.rv;
        mem_rdata_i  = v.rdata;
        #2;
    endtask

    // Reference model state for the random phase
    bit          m_last;
    bit          m_pend;
    bit          m_powner;
    bit          mq[$];
    bit          ireq_h, dreq_h;
    logic [31:0] iaddr_h, daddr_h, dwdata_h;
    logic        dwe_h;
    logic [3:0]  dbe_h;

    initial begin
        // ireq iaddr dreq daddr we be wdata gnt rv rdata | req addr we be wdata igt dgt irv drv
        vecs[0]  = '{1, 32'h100, 0, 0, 0, 4'h0, 0, 1, 0, 0,
                     1, 32'h100, 0, 4'hF, 0, 1, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h13,
                     0, 0, 0, 4'h0, 0, 0, 0, 1, 0};
        vecs[2]  = '{0, 0, 1, 32'h80, 1, 4'h3, 32'hDEADBEEF, 1, 0, 0,
                     1, 32'h80, 1, 4'h3, 32'hDEADBEEF, 0, 1, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h0,
                     0, 0, 0, 4'h0, 0, 0, 0, 0, 1};
        vecs[4]  = '{1, 32'h200, 0, 0, 0, 4'h0, 0, 0, 0, 0,
                     1, 32'h200, 0, 4'hF, 0, 0, 0, 0, 0};
        vecs[5]  = '{1, 32'h200, 1, 32'h44, 1, 4'hF, 32'h55, 0, 0, 0,
                     1, 32'h200, 0, 4'hF, 0, 0, 0, 0, 0};
        vecs[6]  = vecs[5];
        vecs[7]  = '{1, 32'h200, 1, 32'h44, 1, 4'hF, 32'h55, 1, 0, 0,
                     1, 32'h200, 0, 4'hF, 0, 1, 0, 0, 0};
        vecs[8]  = '{0, 0, 1, 32'h44, 1, 4'hF, 32'h55, 1, 0, 0,
                     1, 32'h44, 1, 4'hF, 32'h55, 0, 1, 0, 0};
        vecs[9]  = '{1, 32'h300, 0, 0, 0, 4'h0, 0, 1, 1, 32'h11,
                     0, 0, 0, 4'h0, 0, 0, 0, 1, 0};
        vecs[10] = '{1, 32'h300, 0, 0, 0, 4'h0, 0, 1, 1, 32'h22,
                     1, 32'h300, 0, 4'hF, 0, 1, 0, 0, 1};
        vecs[11] = '{0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h33,
                     0, 0, 0, 4'h0, 0, 0, 0, 1, 0};

        // Outputs must be quiet while reset is held, whatever the inputs do
        idleInputs();
        rst_ni       = 1'b0;
        instr_req_i  = 1'b1;
        data_req_i   = 1'b1;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        tick();
        #2;
        checkOutput("reset mem_req", mem_req_o, 0);
        checkOutput("reset instr_gnt", instr_gnt_o, 0);
        checkOutput("reset data_gnt", data_gnt_o, 0);
        checkOutput("reset instr_rvalid", instr_rvalid_o, 0);
        checkOutput("reset data_rvalid", data_rvalid_o, 0);

        // Vector table: fetch, store routing, lock hold, full stall
        doReset();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d mem_req", i), mem_req_o, vecs[i].e_req);
            checkOutput($sformatf("vec%0d instr_gnt", i), instr_gnt_o, vecs[i].e_igt);
            checkOutput($sformatf("vec%0d data_gnt", i), data_gnt_o, vecs[i].e_dgt);
            checkOutput($sformatf("vec%0d instr_rvalid", i), instr_rvalid_o, vecs[i].e_irv);
            checkOutput($sformatf("vec%0d data_rvalid", i), data_rvalid_o, vecs[i].e_drv);
            if (vecs[i].e_req) begin
                checkOutput($sformatf("vec%0d mem_addr", i), mem_addr_o, vecs[i].e_addr);
                checkOutput($sformatf("vec%0d mem_we", i), mem_we_o, vecs[i].e_we);
                checkOutput($sformatf("vec%0d mem_be", i), mem_be_o, vecs[i].e_be);
                checkOutput($sformatf("vec%0d mem_wdata", i), mem_wdata_o, vecs[i].e_wdata);
            end
            if (vecs[i].e_irv) checkOutput($sformatf("vec%0d instr_rdata", i), instr_rdata_o, vecs[i].rdata);
            if (vecs[i].e_drv) checkOutput($sformatf("vec%0d data_rdata", i), data_rdata_o, vecs[i].rdata);
            tick();
        end

        // Contention: grants alternate starting with instr, responses follow
        doReset();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h1000;
        data_req_i   = 1'b1;
        data_addr_i  = 32'h2000;
        mem_gnt_i    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem_rvalid_i = (i > 0);
            mem_rdata_i  = i;
            #2;
            checkOutput($sformatf("rr%0d instr_gnt", i), instr_gnt_o, (i % 2) == 0);
            checkOutput($sformatf("rr%0d data_gnt", i), data_gnt_o, (i % 2) == 1);
            if (i > 0) begin
                checkOutput($sformatf("rr%0d instr_rvalid", i), instr_rvalid_o, (i % 2) == 1);
                checkOutput($sformatf("rr%0d data_rvalid", i), data_rvalid_o, (i % 2) == 0);
            end
            tick();
        end

        // Full: two grants, responses 5 cycles late, new grant after the pop
        doReset();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h400;
        mem_gnt_i    = 1'b1;
        #2;
        checkOutput("full c0 instr_gnt", instr_gnt_o, 1);
        tick();
        instr_req_i = 1'b0;
        data_req_i  = 1'b1;
        data_addr_i = 32'h500;
        #2;
        checkOutput("full c1 data_gnt", data_gnt_o, 1);
        tick();
        data_req_i   = 1'b0;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h600;
        for (int i = 2; i < 5; i++) begin
            #2;
            checkOutput($sformatf("full c%0d mem_req", i), mem_req_o, 0);
            checkOutput($sformatf("full c%0d instr_gnt", i), instr_gnt_o, 0);
            tick();
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hA;
        #2;
        checkOutput("full pop mem_req", mem_req_o, 0);
        checkOutput("full pop instr_gnt", instr_gnt_o, 0);
        checkOutput("full pop instr_rvalid", instr_rvalid_o, 1);
        tick();
        mem_rvalid_i = 1'b0;
        #2;
        checkOutput("full after mem_req", mem_req_o, 1);
        checkOutput("full after instr_gnt", instr_gnt_o, 1);
        checkOutput("full after mem_addr", mem_addr_o, 32'h600);
        tick();
        instr_req_i  = 1'b0;
        mem_rvalid_i = 1'b1;
        #2;
        checkOutput("full 2nd data_rvalid", data_rvalid_o, 1);
        checkOutput("full 2nd instr_rvalid", instr_rvalid_o, 0);
        tick();
        #2;
        checkOutput("full 3rd instr_rvalid", instr_rvalid_o, 1);
        tick();
        idleInputs();

        // Reset mid-flight: outstanding ownership is discarded
        doReset();
        instr_req_i = 1'b1;
        mem_gnt_i   = 1'b1;
        #2;
        checkOutput("rst mf grant", instr_gnt_o, 1);
        tick();
        rst_ni     = 1'b0;
        data_req_i = 1'b1;
        #2;
        checkOutput("rst mf mem_req low", mem_req_o, 0);
        checkOutput("rst mf gnt low", instr_gnt_o | data_gnt_o, 0);
        tick();
        rst_ni       = 1'b1;
        instr_req_i  = 1'b0;
        data_req_i   = 1'b0;
        mem_rvalid_i = 1'b1;
        #2;
        checkOutput("rst mf instr_rvalid", instr_rvalid_o, 0);
        checkOutput("rst mf data_rvalid", data_rvalid_o, 0);
        checkOutput("rst mf count", 32'(dut.count_q), 0);
        tick();
        mem_rvalid_i = 1'b0;
        instr_req_i  = 1'b1;
        data_req_i   = 1'b1;
        #2;
        checkOutput("rst mf tie instr_gnt", instr_gnt_o, 1);
        checkOutput("rst mf tie data_gnt", data_gnt_o, 0);
        tick();

        // Random phase against the reference model
        doReset();
        m_last = 1'b1;
        m_pend = 1'b0;
        mq.delete();
        ireq_h = 1'b0;
        dreq_h = 1'b0;
        for (int c = 0; c < 400; c++) begin
            bit own, e_req, e_igt, e_dgt, e_irv, e_drv, rv;
            if (!ireq_h && $urandom_range(0, 2) != 0) begin
                ireq_h  = 1'b1;
                iaddr_h = $urandom;
            end
            if (!dreq_h && $urandom_range(0, 2) != 0) begin
                dreq_h   = 1'b1;
                daddr_h  = $urandom;
                dwe_h    = 1'($urandom_range(0, 1));
                dbe_h    = 4'($urandom);
                dwdata_h = $urandom;
            end
            rv = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
            instr_req_i  = ireq_h;
            instr_addr_i = iaddr_h;
            data_req_i   = dreq_h;
            data_addr_i  = daddr_h;
            data_we_i    = dwe_h;
            data_be_i    = dbe_h;
            data_wdata_i = dwdata_h;
            mem_gnt_i    = ($urandom_range(0, 3) != 0);
            mem_rvalid_i = rv;
            mem_rdata_i  = $urandom;
            #2;
            e_req = (ireq_h || dreq_h) && (mq.size() < MaxOut);
            if (m_pend) own = m_powner;
            else if (ireq_h && dreq_h) own = !m_last;
            else own = dreq_h;
            e_igt = e_req && mem_gnt_i && !own;
            e_dgt = e_req && mem_gnt_i && own;
            e_irv = rv && (mq[0] == 1'b0);
            e_drv = rv && (mq[0] == 1'b1);
            checkOutput($sformatf("rnd%0d mem_req", c), mem_req_o, e_req);
            checkOutput($sformatf("rnd%0d instr_gnt", c), instr_gnt_o, e_igt);
            checkOutput($sformatf("rnd%0d data_gnt", c), data_gnt_o, e_dgt);
            checkOutput($sformatf("rnd%0d instr_rvalid", c), instr_rvalid_o, e_irv);
            checkOutput($sformatf("rnd%0d data_rvalid", c), data_rvalid_o, e_drv);
            if (e_req) begin
                checkOutput($sformatf("rnd%0d mem_addr", c), mem_addr_o, own ? daddr_h : iaddr_h);
                checkOutput($sformatf("rnd%0d mem_we", c), mem_we_o, own ? dwe_h : 1'b0);
                checkOutput($sformatf("rnd%0d mem_be", c), mem_be_o, own ? dbe_h : 4'hF);
            end
            if (rv) void'(mq.pop_front());
            if (e_igt || e_dgt) begin
                mq.push_back(own);
                m_last = own;
                m_pend = 1'b0;
            end else if (e_req) begin
                m_pend   = 1'b1;
                m_powner = own;
            end
            if (e_igt) ireq_h = 1'b0;
            if (e_dgt) dreq_h = 1'b0;
            tick();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/panda_mem_arbiter.md
# panda_mem_arbiter

Shares a single OBI-style memory port between the instruction fetch port and the load-store port of the Panda core, enabling a unified instruction/data memory. It sits between the core's fetch/LSU interfaces and the memory. It uses round-robin arbitration with a locked pending decision. A small in-order ownership FIFO routes each read response back to the requester that issued the transaction.

## Interface
- MaxOutstanding, 2, maximum granted-but-unanswered transactions on the memory port (≥1).
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset, synchronous, active-low.
- instr_req_i  input  1  fetch request; held with address stable until granted.
- instr_addr_i  input  32  fetch address.
- instr_gnt_o  output  1  fetch request accepted this cycle.
- instr_rvalid_o  output  1  fetch response valid.
- instr_rdata_o  output  32  fetch response data.
- data_req_i  input  1  LSU request; held with attributes stable until granted.
- data_addr_i  input  32  LSU address.
- data_we_i  input  1  1 = store.
- data_be_i  input  4  byte enables.
- data_wdata_i  input  32  store data.
- data_gnt_o  output  1  LSU request accepted this cycle.
- data_rvalid_o  output  1  LSU response valid (loads and stores).
- data_rdata_o  output  32  LSU load data.
- mem_req_o  output  1  memory request.
- mem_addr_o  output  32  memory address.
- mem_we_o  output  1  memory write enable.
- mem_be_o  output  4  memory byte enables.
- mem_wdata_o  output  32  memory write data.
- mem_gnt_i  input  1  memory accepted request.
- mem_rvalid_i  input  1  memory response valid; in order, at least 1 cycle after its gnt.
- mem_rdata_i  input  32  memory response data.

## Operation
- State: `last_q` (1 bit, last granted requester, 0 = instr, 1 = data); `lock_q` and `lock_owner_q` (pending, not-yet-granted decision); ownership FIFO of MaxOutstanding 1-bit entries with read pointer, write pointer, and count of width $clog2(MaxOutstanding+1).
- Selection:
  - If `lock_q`, the owner is `lock_owner_q`.
  - Otherwise, if only one requester is asserted, it is the owner.
  - If both are asserted, the owner is the requester other than `last_q`.
- mem_req_o = (instr_req_i | data_req_i) & ~full & rst_ni.
- mem_addr/we/be/wdata are muxed from the owner. Fetch drives mem_we_o = 0, mem_be_o = 4'hF, and mem_wdata_o = 0.
- Owner gnt = mem_req_o & mem_gnt_i. The non-owner gnt is always 0.
- mem_req_o & ~mem_gnt_i sets `lock_q` and records the owner. This keeps the request stable for the memory until accepted.
- A grant clears `lock_q`, sets `last_q` to the owner, and pushes the owner into the FIFO.
- mem_rvalid_i pops the FIFO head. The response is routed to instr_rvalid_o or data_rvalid_o.
- instr_rdata_o and data_rdata_o both pass mem_rdata_i combinationally. Rdata is only meaningful with the corresponding rvalid.
- Full (count == MaxOutstanding): mem_req_o = 0 and no grants, even if rvalid pops in the same cycle. Requests wait one more cycle.
- Simultaneous grant and rvalid: push and pop both occur, and the count is unchanged. Pointers wrap modulo MaxOutstanding.
- mem_rvalid_i with an empty FIFO is a protocol violation. It produces no rvalid output and leaves the state unchanged. A simulation assertion flags it.
- A locked owner dropping its request before grant is a protocol violation. The lock clears, and a simulation assertion flags it.

## Timing
- Grant is combinational in the same cycle as mem_gnt_i, with zero added latency. Request-to-memory latency is 0 cycles.
- Response routing is combinational: the rvalid output asserts in the same cycle as mem_rvalid_i.
- Reset (rst_ni low at a clock edge):
  - `last_q` = 1, so instr wins the first tie.
  - `lock_q` = 0, the FIFO is empty, and the pointers are 0.
- While rst_ni is low, mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o and data_rvalid_o are 0. Address, data and rdata outputs are don't-care.
- Reset mid-transaction discards all outstanding ownership. Memory responses after reset with an empty FIFO are dropped per the empty rule.
- Throughput: one grant per cycle when not full. With both requesters always asserting, grants strictly alternate.

## Test plan
- Single fetch: instr_req with addr 0x100, mem_gnt same cycle, mem_rvalid next cycle with rdata 0x00000013. Required: instr_gnt=1 in cycle 0; instr_rvalid=1 and instr_rdata=0x13 in cycle 1; data_rvalid stays 0.
- Contention: both requesters asserted continuously, mem_gnt=1, MaxOutstanding=2, rvalid 1 cycle after each gnt. Required: grant order instr, data, instr, data… starting with instr after reset. Responses route to the matching port in the same order.
- Lock: instr requests at 0x200, mem_gnt=0 for 3 cycles, and data_req asserts in cycle 1. Required: mem_addr_o stays 0x200 and mem_we_o stays 0 until gnt. Data is granted on the next cycle.
- Full: MaxOutstanding=2, two grants issued, responses delayed 5 cycles. Required: mem_req_o=0 until the first mem_rvalid. The first new grant comes the cycle after that pop, never during it.
- Store routing: data store at addr 0x80, be 4'b0011, wdata 0xDEADBEEF. Required: mem_we=1, mem_be=0x3 and mem_wdata=0xDEADBEEF in the gnt cycle. data_rvalid (not instr_rvalid) asserts on the response.
- Reset mid-flight: 1 outstanding, then rst_ni=0 for 1 cycle, then mem_rvalid. Required: no rvalid on either port, count=0, and the next tie is granted to instr.
